// File: rtl/rst_seq_ctrl_pkg.sv
// Shared types and default timing for the reset sequencer.
// Holds the FSM state encoding and a helper used by the parameter sanity check.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_INIT  = 3'd1,
    S_STEP  = 3'd2,
    S_RUN   = 3'd3,
    S_SWRST = 3'd4
  } state_t;

  localparam int DEF_N_DOM      = 4;
  localparam int DEF_INIT_WAIT  = 16;
  localparam int DEF_STEP_GAP   = 8;
  localparam int DEF_SW_RST_CYC = 4;
  localparam int DEF_CW         = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_sync.sv
// Two-flop synchronizer for the active-low chip reset.
// Assertion is asynchronous; release reaches o_rstn_s on the second clk edge.
module rstn_sync (
  input  logic clk,
  input  logic rstn_in,
  output logic o_rstn_s
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= 1'b1;
      r_sync <= r_meta;
    end
  end

  assign o_rstn_s = r_sync;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: releases N_DOM domain resets in order after chip reset,
// then services per-domain software reset pulses.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int N_DOM      = DEF_N_DOM,
  parameter int INIT_WAIT  = DEF_INIT_WAIT,
  parameter int STEP_GAP   = DEF_STEP_GAP,
  parameter int SW_RST_CYC = DEF_SW_RST_CYC,
  parameter int CW         = DEF_CW
) (
  input  logic             clk,
  input  logic             rstn_in,
  input  logic [N_DOM-1:0] i_sw_rst_req,
  output logic [N_DOM-1:0] o_rstn_dom,
  output logic             o_seq_done,
  output logic             o_busy,
  output logic             o_sw_ack
);

  localparam int IW = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DOM - 1);

  if ((N_DOM < 1) || (INIT_WAIT < 1) || (STEP_GAP < 1) || (SW_RST_CYC < 1)) begin : g_param_zero
    $error("rst_seq_ctrl: N_DOM and all timing parameters must be >= 1");
  end
  if (max3(INIT_WAIT, STEP_GAP, SW_RST_CYC) >= (1 << CW)) begin : g_param_cw
    $error("rst_seq_ctrl: CW too narrow for the timing parameters");
  end

  logic             w_rstn_s;
  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic [N_DOM-1:0] r_dom, w_dom_nxt;
  logic [N_DOM-1:0] r_mask, w_mask_nxt;
  logic             r_done, w_done_nxt;
  logic             r_ack, w_ack_nxt;
  logic             w_rel0;
  logic [N_DOM-1:0] w_idx_bit;

  rstn_sync u_rstn_sync (
    .clk      (clk),
    .rstn_in  (rstn_in),
    .o_rstn_s (w_rstn_s)
  );

  assign w_idx_bit = N_DOM'(1) << r_idx;

  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_dom   <= '0;
      r_mask  <= '0;
      r_done  <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_dom   <= w_dom_nxt;
      r_mask  <= w_mask_nxt;
      r_done  <= w_done_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  // The edge that leaves S_HOLD is already the first counted wait cycle,
  // so INIT_WAIT=1 releases domain 0 straight out of S_HOLD.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_dom_nxt   = r_dom;
    w_mask_nxt  = r_mask;
    w_done_nxt  = r_done;
    w_ack_nxt   = 1'b0;
    w_rel0      = 1'b0;

    case (r_state)
      S_HOLD: begin
        if (w_rstn_s) begin
          if (INIT_WAIT == 1) begin
            w_rel0 = 1'b1;
          end else begin
            w_state_nxt = S_INIT;
            w_cnt_nxt   = CW'(INIT_WAIT - 2);
          end
        end
      end
      S_INIT: begin
        if (r_cnt == '0) begin
          w_rel0 = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_STEP: begin
        if (r_cnt == '0) begin
          w_dom_nxt = r_dom | w_idx_bit;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_RUN;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
            w_cnt_nxt = CW'(STEP_GAP - 1);
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_RUN: begin
        if (|i_sw_rst_req) begin
          w_mask_nxt  = i_sw_rst_req;
          w_dom_nxt   = r_dom & ~i_sw_rst_req;
          w_cnt_nxt   = CW'(SW_RST_CYC - 1);
          w_state_nxt = S_SWRST;
        end
      end
      S_SWRST: begin
        if (r_cnt == '0) begin
          w_dom_nxt   = r_dom | r_mask;
          w_mask_nxt  = '0;
          w_ack_nxt   = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_HOLD;
      end
    endcase

    if (w_rel0) begin
      w_dom_nxt[0] = 1'b1;
      w_idx_nxt    = IW'(1);
      if (N_DOM == 1) begin
        w_state_nxt = S_RUN;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = S_STEP;
        w_cnt_nxt   = CW'(STEP_GAP - 1);
      end
    end
  end

  assign o_rstn_dom = r_dom;
  assign o_seq_done = r_done;
  assign o_busy     = (r_state != S_RUN);
  assign o_sw_ack   = r_ack;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: default config (A) plus a minimal
// N_DOM=1 config (B), both checked every cycle against a timeline model.
module tb_rst_seq_ctrl;

  localparam int ND_A = 4, IW_A = 16, SG_A = 8, SW_A = 4;
  localparam int ND_B = 1, IW_B = 1,  SG_B = 1, SW_B = 4;

  logic       clk = 1'b0;
  logic       rstn_in = 1'b0;
  logic [3:0] reqA = '0;
  logic [0:0] reqB = '0;
  logic [3:0] domA;
  logic [0:0] domB;
  logic       doneA, busyA, ackA;
  logic       doneB, busyB, ackB;

  int checks = 0;
  int errors = 0;
  int n = 0;

  int         swEnd  [2];
  logic [3:0] mask   [2];
  logic [3:0] expDom [2];
  logic       expDone[2];
  logic       expBusy[2];
  logic       expAck [2];

  always #5 clk = ~clk;

  rst_seq_ctrl #(.N_DOM(ND_A), .INIT_WAIT(IW_A), .STEP_GAP(SG_A), .SW_RST_CYC(SW_A), .CW(8)) dutA (
    .clk(clk), .rstn_in(rstn_in), .i_sw_rst_req(reqA),
    .o_rstn_dom(domA), .o_seq_done(doneA), .o_busy(busyA), .o_sw_ack(ackA)
  );

  rst_seq_ctrl #(.N_DOM(ND_B), .INIT_WAIT(IW_B), .STEP_GAP(SG_B), .SW_RST_CYC(SW_B), .CW(8)) dutB (
    .clk(clk), .rstn_in(rstn_in), .i_sw_rst_req(reqB),
    .o_rstn_dom(domB), .o_seq_done(doneB), .o_busy(busyB), .o_sw_ack(ackB)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t (edge %0d)", name, actual, expected, $time, n);
    end
  endtask

  // Edge n of the timeline: domain i is up from edge 2+IW+i*SG, a software
  // reset taken at edge E holds its mask low until edge E+SW.
  task automatic modelStep(input int k, input int nd, input int iw, input int sg, input int sw,
                           input logic [3:0] req, input bit inReset);
    logic [3:0] rel;
    int seqEdge;
    seqEdge = 2 + iw + (nd - 1) * sg;
    expAck[k] = 1'b0;
    if (inReset) begin
      swEnd[k] = -1;
      mask[k]  = '0;
    end else if (swEnd[k] == n) begin
      mask[k]   = '0;
      swEnd[k]  = -1;
      expAck[k] = 1'b1;
    end else if (swEnd[k] < 0 && n > seqEdge && req != 0) begin
      mask[k]  = req;
      swEnd[k] = n + sw;
    end
    rel = '0;
    for (int i = 0; i < nd; i++) if (n >= 2 + iw + i * sg) rel[i] = 1'b1;
    expDom[k]  = rel & ~mask[k];
    expDone[k] = (n >= seqEdge);
    expBusy[k] = !((n >= seqEdge) && (swEnd[k] < 0));
  endtask

  initial begin
    modelStep(0, ND_A, IW_A, SG_A, SW_A, 4'b0, 1'b1);
    modelStep(1, ND_B, IW_B, SG_B, SW_B, 4'b0, 1'b1);
    forever begin
      @(posedge clk or negedge rstn_in);
      if (!rstn_in) begin
        n = 0;
        modelStep(0, ND_A, IW_A, SG_A, SW_A, 4'b0, 1'b1);
        modelStep(1, ND_B, IW_B, SG_B, SW_B, 4'b0, 1'b1);
      end else begin
        n++;
        modelStep(0, ND_A, IW_A, SG_A, SW_A, reqA, 1'b0);
        modelStep(1, ND_B, IW_B, SG_B, SW_B, {3'b000, reqB}, 1'b0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("domA",  domA,  expDom[0]);
      checkOutput("doneA", doneA, expDone[0]);
      checkOutput("busyA", busyA, expBusy[0]);
      checkOutput("ackA",  ackA,  expAck[0]);
      checkOutput("domB",  domB,  expDom[1][0]);
      checkOutput("doneB", doneB, expDone[1]);
      checkOutput("busyB", busyB, expBusy[1]);
      checkOutput("ackB",  ackB,  expAck[1]);
    end
  end

  task automatic applyStimulus(input logic [3:0] a, input logic b);
    reqA = a;
    reqB = b;
  endtask

  // Leaves the caller 1 ns after the target edge.
  task automatic runToEdge(input int target);
    int guard;
    guard = 0;
    while (n < target && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("edgeReach", n, target);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    #2;
    rstn_in = 1'b1;
  endtask

  task automatic powerOnPins(input bit holdReq);
    if (holdReq) applyStimulus(4'b1111, 1'b0);
    runToEdge(2);
    checkOutput("pinB_e2_dom",  domB,  1'b0);
    checkOutput("pinB_e2_done", doneB, 1'b0);
    runToEdge(3);
    checkOutput("pinB_e3_dom",  domB,  1'b1);
    checkOutput("pinB_e3_done", doneB, 1'b1);
    runToEdge(17);
    checkOutput("pinA_e17_dom", domA, 4'b0000);
    runToEdge(18);
    checkOutput("pinA_e18_dom", domA, 4'b0001);
    runToEdge(26);
    checkOutput("pinA_e26_dom", domA, 4'b0011);
    runToEdge(34);
    checkOutput("pinA_e34_dom", domA, 4'b0111);
    runToEdge(41);
    checkOutput("pinA_e41_done", doneA, 1'b0);
    checkOutput("pinA_e41_busy", busyA, 1'b1);
    applyStimulus(4'b0000, 1'b0);
    runToEdge(42);
    checkOutput("pinA_e42_dom",  domA,  4'b1111);
    checkOutput("pinA_e42_done", doneA, 1'b1);
    checkOutput("pinA_e42_busy", busyA, 1'b0);
    runToEdge(47);
    checkOutput("pinA_e47_dom", domA, 4'b1111);
    checkOutput("pinA_e47_ack", ackA, 1'b0);
  endtask

  initial begin
    logic [3:0] rA;
    logic       rB;

    #12;
    checkOutput("rst_dom",  domA,  4'b0000);
    checkOutput("rst_done", doneA, 1'b0);
    checkOutput("rst_busy", busyA, 1'b1);
    checkOutput("rst_ack",  ackA,  1'b0);
    releaseReset();
    powerOnPins(1'b1);

    $display("[TB] single software reset");
    runToEdge(49);
    applyStimulus(4'b0100, 1'b0);
    runToEdge(50);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("sw1_E_dom",  domA,  4'b1011);
    checkOutput("sw1_E_busy", busyA, 1'b1);
    runToEdge(53);
    checkOutput("sw1_E3_dom", domA, 4'b1011);
    checkOutput("sw1_E3_ack", ackA, 1'b0);
    runToEdge(54);
    checkOutput("sw1_E4_dom", domA, 4'b1111);
    checkOutput("sw1_E4_ack", ackA, 1'b1);
    runToEdge(55);
    checkOutput("sw1_E5_ack", ackA, 1'b0);

    $display("[TB] multi-bit request with an ignored follow-up");
    runToEdge(59);
    applyStimulus(4'b1001, 1'b0);
    runToEdge(60);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("sw2_E_dom", domA, 4'b0110);
    runToEdge(61);
    applyStimulus(4'b0010, 1'b0);
    runToEdge(62);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("sw2_E2_dom", domA, 4'b0110);
    runToEdge(64);
    checkOutput("sw2_E4_dom", domA, 4'b1111);
    checkOutput("sw2_E4_ack", ackA, 1'b1);
    runToEdge(65);
    checkOutput("sw2_E5_ack", ackA, 1'b0);
    checkOutput("sw2_E5_dom", domA, 4'b1111);

    $display("[TB] randomized requests");
    for (int c = 0; c < 400; c++) begin
      rA = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      rB = ($urandom_range(0, 6) == 0);
      applyStimulus(rA, rB);
      runToEdge(n + 1);
    end
    applyStimulus(4'b0000, 1'b0);
    runToEdge(n + 8);

    $display("[TB] reset mid-sequence");
    rstn_in = 1'b0;
    repeat (2) @(posedge clk);
    releaseReset();
    runToEdge(30);
    checkOutput("mid_e30_dom", domA, 4'b0011);
    #1;
    rstn_in = 1'b0;
    #1;
    checkOutput("mid_async_dom",  domA,  4'b0000);
    checkOutput("mid_async_done", doneA, 1'b0);
    checkOutput("mid_async_busy", busyA, 1'b1);
    checkOutput("mid_async_domB", domB,  1'b0);
    repeat (2) @(posedge clk);
    releaseReset();
    powerOnPins(1'b0);

    $display("[TB] sub-cycle reset glitch");
    runToEdge(50);
    #1;
    rstn_in = 1'b0;
    #1;
    rstn_in = 1'b1;
    #1;
    checkOutput("glitch_dom",  domA,  4'b0000);
    checkOutput("glitch_done", doneA, 1'b0);
    powerOnPins(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Reset sequencer that sits downstream of the chip reset input.
- Synchronizes rstn_in internally, then releases N_DOM domain resets one after another with programmable gaps.
- Once all domains are released, it serves per-domain software reset requests by pulsing the selected domain resets for a fixed length.
- Feeds the active-low resets of the NPU sub-blocks (core, DMA, buffers, NoC) so that they come out of reset in a deterministic order.

Parameters:
- N_DOM, 4: number of reset domains (>=1).
- INIT_WAIT, 16: cycles between synchronized reset release and domain 0 release (>=1).
- STEP_GAP, 8: cycles between release of domain i-1 and domain i (>=1).
- SW_RST_CYC, 4: cycles a software-reset domain is held low (>=1).
- CW, 8: counter width; must hold max(INIT_WAIT, STEP_GAP, SW_RST_CYC).

Ports:
- clk  in  1  clock.
- rstn_in  in  1  reset, asynchronous, active-low.
- i_sw_rst_req  in  N_DOM  software reset request, one bit per domain; sampled only in S_RUN.
- o_rstn_dom  out  N_DOM  per-domain active-low reset.
- o_seq_done  out  1  high once all domains are released by the power-on sequence.
- o_busy  out  1  high whenever FSM is not in S_RUN.
- o_sw_ack  out  1  one-cycle pulse when a software reset completes.

Behaviour:
- Reset values: o_rstn_dom=0, o_seq_done=0, o_busy=1, o_sw_ack=0.
- All flops use asynchronous reset on rstn_in.
- rstn_in goes through a 2-flop synchronizer. Its output rstn_s is 0 in reset and 1 after the 2nd clk edge following deassertion.
- Edge numbering: edge 1 is the first rising clk edge with rstn_in high.
- FSM states: S_HOLD, S_INIT, S_STEP, S_RUN, S_SWRST. Single down-counter cnt[CW-1:0] and domain index idx.
- S_HOLD: all domains low. Exits to S_INIT when rstn_s=1, loading cnt.
- S_INIT: counts INIT_WAIT. o_rstn_dom[0] rises at edge 2+INIT_WAIT. Then idx=1.
  - If N_DOM=1: go directly to S_RUN; o_seq_done rises on the same edge as dom[0].
  - Otherwise: go to S_STEP.
- S_STEP: o_rstn_dom[idx] rises STEP_GAP edges after o_rstn_dom[idx-1].
  - After dom[N_DOM-1] rises: enter S_RUN; o_seq_done rises on that same edge.
- Released domains stay high; bits never toggle out of order.
- S_RUN: o_busy=0. If any bit of i_sw_rst_req is 1 at edge E:
  - Latch mask=i_sw_rst_req and enter S_SWRST.
  - o_rstn_dom&~mask holds from edge E (masked bits are 0 after edge E).
  - o_busy=1 after edge E.
- S_SWRST: hold for SW_RST_CYC cycles. At edge E+SW_RST_CYC:
  - All masked bits return to 1 simultaneously.
  - o_sw_ack=1 for exactly that one cycle.
  - FSM returns to S_RUN.
- Requests outside S_RUN, including bits that change during S_SWRST, are ignored (not queued). Requesters must watch o_busy.
- Multiple request bits in the same cycle are serviced together as one reset.
- o_seq_done stays 1 through S_SWRST. It only clears on rstn_in.
- rstn_in asserted at any time: all outputs take reset values asynchronously, and the full sequence restarts after deassertion.
- rstn_in glitch shorter than one cycle: still forces a full restart, because of the async clear.
- Counter compares against parameter-1; no wrap in legal use. Parameters of 0 are illegal; the implementation asserts this in simulation.

Decomposition:
- Shared package rst_seq_pkg holds:
  - state enum localparams S_HOLD=0, S_INIT=1, S_STEP=2, S_RUN=3, S_SWRST=4 (3 bits);
  - default timing constants.
- Sub-module: the existing rstn_sync 2-flop synchronizer, instantiated once on rstn_in/clk to produce rstn_s.
- Everything else lives in one always block set in rst_seq_ctrl.

Test Plan:
- Power-on, defaults: release rstn_in → o_rstn_dom = 0001 at edge 18, 0011 at 26, 0111 at 34, 1111 at 42; o_seq_done=1 and o_busy=0 at edge 42.
- SW reset single: at edge E in S_RUN, i_sw_rst_req=0100 for one cycle → o_rstn_dom=1011 for edges E..E+3; 1111 at E+4; o_sw_ack=1 only in cycle E+4.
- SW reset multi plus ignored request: i_sw_rst_req=1001 at E, then 0010 at E+2 → only bits 3 and 0 pulse low; bit 1 stays 1; exactly one o_sw_ack.
- Mid-sequence reset: assert rstn_in at edge 30 (dom=0011) → o_rstn_dom=0000 and o_seq_done=0 immediately; after re-release, the timing of scenario 1 repeats exactly.
- Request before done: i_sw_rst_req=1111 held from edge 1 to 41, dropped at 42 → no SW reset, no o_sw_ack; sequence unaffected.
- Parameter sweep: N_DOM=1, INIT_WAIT=1, STEP_GAP=1 → o_rstn_dom[0] and o_seq_done rise at edge 3.
